// File: rtl/transport_tx_scheduler.sv
// Transmit scheduler: arbitrates session control words and audio samples
// onto one byte stream, framing each grant as a fixed-size padded packet.
module transport_tx_scheduler #(
    parameter int          PACKET_SIZE  = 16,
    parameter int          MAX_CTRL_RUN = 4,
    parameter logic [7:0]  CTRL_HDR     = 8'h40,
    parameter logic [7:0]  AUDIO_HDR    = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic        ctrl_req,
    input  logic [15:0] ctrl_data,
    output logic        ctrl_ack,
    input  logic [9:0]  audio_level,
    input  logic        audio_valid,
    input  logic [15:0] audio_sample,
    output logic        audio_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    output logic        busy,
    output logic [1:0]  grant
);
    localparam int SAMPLES_PER_PKT = (PACKET_SIZE - 1) / 2;
    localparam int AUDIO_PAD = PACKET_SIZE - 1 - 2 * SAMPLES_PER_PKT;
    localparam int CTRL_PAD = PACKET_SIZE - 3;
    localparam int BW = $clog2(PACKET_SIZE) + 1;
    localparam int SW = $clog2(SAMPLES_PER_PKT + 1);
    localparam int RW = $clog2(MAX_CTRL_RUN + 1);

    typedef enum logic [2:0] {
        IDLE, HDR, C_HI, C_LO, A_LOAD, A_HI, A_LO, PAD
    } stateT;

    stateT          state;
    logic [RW-1:0]  ctrlRun;
    logic [BW-1:0]  byteCnt;
    logic [SW-1:0]  sampleCnt;
    logic [15:0]    ctrlWord;
    logic [15:0]    audioWord;
    logic           audioPend;
    logic           ctrlWins;
    logic           txHs;

    assign audioPend = audio_level >= 10'(SAMPLES_PER_PKT);
    assign ctrlWins = ctrl_req && (ctrlRun < RW'(MAX_CTRL_RUN) || !audioPend);
    assign txHs = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ctrlRun     <= '0;
            byteCnt     <= '0;
            sampleCnt   <= '0;
            ctrlWord    <= '0;
            audioWord   <= '0;
            ctrl_ack    <= 1'b0;
            audio_ready <= 1'b0;
            tx_valid    <= 1'b0;
            tx_byte     <= '0;
            busy        <= 1'b0;
            grant       <= 2'b00;
        end else begin
            ctrl_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_enable && ctrlWins) begin
                        ctrlWord <= ctrl_data;
                        ctrl_ack <= 1'b1;
                        grant    <= 2'b01;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_byte  <= CTRL_HDR;
                        state    <= HDR;
                        if (ctrlRun != RW'(MAX_CTRL_RUN))
                            ctrlRun <= ctrlRun + RW'(1);
                    end else if (tx_enable && audioPend) begin
                        ctrlRun   <= '0;
                        sampleCnt <= '0;
                        grant     <= 2'b10;
                        busy      <= 1'b1;
                        tx_valid  <= 1'b1;
                        tx_byte   <= AUDIO_HDR;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (txHs && grant == 2'b01) begin
                        tx_byte <= ctrlWord[15:8];
                        state   <= C_HI;
                    end else if (txHs) begin
                        tx_valid    <= 1'b0;
                        audio_ready <= 1'b1;
                        state       <= A_LOAD;
                    end
                end
                C_HI: begin
                    if (txHs) begin
                        tx_byte <= ctrlWord[7:0];
                        state   <= C_LO;
                    end
                end
                C_LO: begin
                    if (txHs && CTRL_PAD == 0) begin
                        tx_valid <= 1'b0;
                        tx_byte  <= '0;
                        busy     <= 1'b0;
                        grant    <= 2'b00;
                        state    <= IDLE;
                    end else if (txHs) begin
                        tx_byte <= '0;
                        byteCnt <= BW'(CTRL_PAD);
                        state   <= PAD;
                    end
                end
                // Stalls here for as long as the audio FIFO runs dry.
                A_LOAD: begin
                    if (audio_valid) begin
                        audioWord   <= audio_sample;
                        audio_ready <= 1'b0;
                        sampleCnt   <= sampleCnt + SW'(1);
                        tx_valid    <= 1'b1;
                        tx_byte     <= audio_sample[15:8];
                        state       <= A_HI;
                    end
                end
                A_HI: begin
                    if (txHs) begin
                        tx_byte <= audioWord[7:0];
                        state   <= A_LO;
                    end
                end
                A_LO: begin
                    if (txHs && sampleCnt < SW'(SAMPLES_PER_PKT)) begin
                        tx_valid    <= 1'b0;
                        audio_ready <= 1'b1;
                        state       <= A_LOAD;
                    end else if (txHs && AUDIO_PAD == 0) begin
                        tx_valid <= 1'b0;
                        tx_byte  <= '0;
                        busy     <= 1'b0;
                        grant    <= 2'b00;
                        state    <= IDLE;
                    end else if (txHs) begin
                        tx_byte <= '0;
                        byteCnt <= BW'(AUDIO_PAD);
                        state   <= PAD;
                    end
                end
                PAD: begin
                    if (txHs && byteCnt == BW'(1)) begin
                        byteCnt  <= '0;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        grant    <= 2'b00;
                        state    <= IDLE;
                    end else if (txHs) begin
                        byteCnt <= byteCnt - BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
